// File: rtl/grf_pkg.sv
// Shared constants for the general register file and its pending-write scoreboard.
// Default geometry matches the RV32 integer register file.
package grf_pkg;

  localparam int GRF_DATA_W = 32;
  localparam int GRF_ADDR_W = 5;
  localparam int GRF_NUM_RD = 2;
  localparam int GRF_CNT_W  = 2;

  localparam int ZERO_REG = 0;

endpackage

// File: rtl/grf_busy_table.sv
// Per-register pending-write counters: issue reservations, writeback release,
// busy lookup for each read port and the sticky unexpected-writeback error.
module grf_busy_table
  import grf_pkg::*;
#(
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int NUM_RD = GRF_NUM_RD,
  parameter int CNT_W  = GRF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ready,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  output logic                     err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0] cnt [DEPTH];

  logic iss_nz;
  logic wr_nz;
  logic wr_hit_iss;
  logic inc;
  logic dec;
  logic same;
  logic bad_wb;

  assign iss_nz     = iss_addr != ZERO;
  assign wr_nz      = wr_addr != ZERO;
  assign wr_hit_iss = wr_en && wr_addr == iss_addr;

  // A same-cycle writeback to a saturated register frees the slot it needs.
  assign iss_ready = reset ||
    !(iss_nz && cnt[iss_addr] == CMAX && !wr_hit_iss);

  assign inc    = iss_en && iss_ready && iss_nz;
  assign dec    = wr_en && wr_nz && cnt[wr_addr] != '0;
  assign same   = inc && dec && iss_addr == wr_addr;
  assign bad_wb = wr_en && wr_nz && cnt[wr_addr] == '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        cnt[r] <= '0;
      end
      err <= 1'b0;
    end else begin
      if (bad_wb) begin
        err <= 1'b1;
      end
      if (!same) begin
        if (inc) begin
          cnt[iss_addr] <= cnt[iss_addr] + 1'b1;
        end
        if (dec) begin
          cnt[wr_addr] <= cnt[wr_addr] - 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_busy
    logic [ADDR_W-1:0] a;
    logic              hit;
    logic              b;

    assign a   = rd_addr[g*ADDR_W +: ADDR_W];
    assign hit = wr_en && wr_addr == a;

    // Busy means writes remain after this cycle's writeback retires.
    always_comb begin
      b = 1'b0;
      if (!reset && a != ZERO) begin
        b = hit ? (cnt[a] > CNT_W'(1)) : (cnt[a] != '0);
      end
    end

    assign rd_busy[g] = b;
  end

endmodule

// File: rtl/grf_scoreboard.sv
// General register file with write-first forwarding and an integrated
// pending-write scoreboard feeding the hazard unit.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int NUM_RD = GRF_NUM_RD,
  parameter int CNT_W  = GRF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ready,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] rf [DEPTH];
  logic              wr_nz;

  assign wr_nz = wr_addr != ZERO;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        rf[r] <= '0;
      end
    end else if (wr_en && wr_nz) begin
      rf[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;

    assign a = rd_addr[g*ADDR_W +: ADDR_W];

    always_comb begin
      v = '0;
      if (a == ZERO) begin
        v = '0;
      end else if (wr_en && wr_addr == a) begin
        v = wr_data;
      end else if (!reset) begin
        v = rf[a];
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = v;
  end

  grf_busy_table #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .CNT_W  (CNT_W)
  ) u_busy (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .err       (err)
  );

endmodule

// File: tb/tb_grf_scoreboard.sv
// Randomized and directed bench for grf_scoreboard against a behavioural
// register-file / reservation-count model.
module tb_grf_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int CW = 2;
  localparam int NREG = 1 << AW;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]  rd_busy;
  logic           iss_en;
  logic [AW-1:0]  iss_addr;
  logic           iss_ready;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           err;

  grf_scoreboard #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_rf [NREG];
  int            m_cnt [NREG];
  bit            m_err;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int a);
    if (a == 0) return '0;
    if (wr_en && int'(wr_addr) == a) return wr_data;
    if (reset) return '0;
    return m_rf[a];
  endfunction

  function automatic bit exp_busy(input int a);
    int hit;
    if (reset || a == 0) return 1'b0;
    hit = (wr_en && int'(wr_addr) == a) ? 1 : 0;
    return (m_cnt[a] - hit) > 0;
  endfunction

  function automatic bit exp_ready();
    int ia;
    if (reset) return 1'b1;
    ia = int'(iss_addr);
    if (ia == 0) return 1'b1;
    if (m_cnt[ia] < CMAX) return 1'b1;
    return wr_en && int'(wr_addr) == ia;
  endfunction

  task automatic drive(input bit r, input bit ie, input int ia, input bit we,
                       input int wa, input logic [DW-1:0] wd,
                       input int a0, input int a1);
    reset    = r;
    iss_en   = ie;
    iss_addr = AW'(ia);
    wr_en    = we;
    wr_addr  = AW'(wa);
    wr_data  = wd;
    rd_addr  = {AW'(a1), AW'(a0)};
  endtask

  task automatic settle();
    int a;
    #3;
    for (int i = 0; i < NR; i++) begin
      a = int'(rd_addr[i*AW +: AW]);
      check($sformatf("rd_data%0d r%0d", i, a), 64'(rd_data[i*DW +: DW]),
            64'(exp_rd(a)));
      check($sformatf("rd_busy%0d r%0d", i, a), 64'(rd_busy[i]),
            64'(exp_busy(a)));
    end
    check("iss_ready", 64'(iss_ready), 64'(exp_ready()));
    check("err", 64'(err), 64'(m_err));
  endtask

  task automatic tick();
    int  wa;
    int  ia;
    bit  inc;
    bit  dec;
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        m_rf[r]  = '0;
        m_cnt[r] = 0;
      end
      m_err = 1'b0;
    end else begin
      wa  = int'(wr_addr);
      ia  = int'(iss_addr);
      inc = iss_en && exp_ready() && ia != 0;
      dec = wr_en && wa != 0 && m_cnt[wa] != 0;
      if (wr_en && wa != 0) begin
        if (m_cnt[wa] == 0) m_err = 1'b1;
        m_rf[wa] = wr_data;
      end
      if (!(inc && dec && ia == wa)) begin
        if (inc) m_cnt[ia] = m_cnt[ia] + 1;
        if (dec) m_cnt[wa] = m_cnt[wa] - 1;
      end
    end
    #1;
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) begin
      m_rf[r]  = '0;
      m_cnt[r] = 0;
    end
    m_err = 1'b0;

    drive(1, 0, 0, 0, 0, '0, 0, 0);
    @(posedge clk);
    #1;
    tick();
    cycle();

    drive(0, 0, 0, 1, 5, 32'h1234_5678, 0, 0);
    cycle();
    drive(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 5, 0);
    settle();
    check("r5 read", 64'(rd_data[31:0]), 64'h1234_5678);
    tick();
    drive(0, 0, 0, 0, 0, '0, 0, 5);
    settle();
    check("r0 read", 64'(rd_data[31:0]), 64'h0);
    tick();

    drive(0, 0, 0, 1, 7, 32'hDEAD_BEEF, 8, 7);
    settle();
    check("fwd p1", 64'(rd_data[63:32]), 64'hDEAD_BEEF);
    check("fwd p0 r8", 64'(rd_data[31:0]), 64'h0);
    tick();

    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 3, 0, 0, '0, 3, 0);
      settle();
      check("r3 issue ready", 64'(iss_ready), 64'h1);
      tick();
    end
    drive(0, 1, 3, 0, 0, '0, 3, 0);
    settle();
    check("r3 busy", 64'(rd_busy[0]), 64'h1);
    check("r3 sat ready", 64'(iss_ready), 64'h0);
    tick();
    drive(0, 1, 3, 1, 3, 32'h33, 3, 0);
    settle();
    check("r3 iss+wb ready", 64'(iss_ready), 64'h1);
    tick();

    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1, 3, DW'(k), 3, 0);
      settle();
      check("r3 drain busy", 64'(rd_busy[0]), 64'(k < 2));
      tick();
    end
    drive(0, 0, 0, 1, 3, 32'hABCD, 3, 0);
    cycle();
    drive(0, 0, 0, 0, 0, '0, 3, 0);
    settle();
    check("r3 err", 64'(err), 64'h1);
    check("r3 data", 64'(rd_data[31:0]), 64'hABCD);
    check("r3 idle", 64'(rd_busy[0]), 64'h0);
    tick();

    drive(0, 1, 9, 0, 0, '0, 9, 0);
    cycle();
    drive(0, 1, 9, 1, 9, 32'h99, 9, 0);
    cycle();
    drive(0, 0, 0, 0, 0, '0, 9, 0);
    settle();
    check("r9 count1 busy", 64'(rd_busy[0]), 64'h1);
    tick();
    drive(0, 1, 0, 0, 0, '0, 0, 9);
    settle();
    check("r0 ready", 64'(iss_ready), 64'h1);
    check("r0 busy", 64'(rd_busy[0]), 64'h0);
    tick();

    drive(0, 1, 3, 0, 0, '0, 3, 9);
    cycle();
    cycle();
    drive(1, 0, 0, 0, 0, '0, 3, 9);
    cycle();
    drive(0, 0, 0, 0, 0, '0, 3, 9);
    settle();
    check("rst err", 64'(err), 64'h0);
    check("rst busy", 64'(rd_busy), 64'h0);
    check("rst data", 64'(rd_data), 64'h0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) == 0,
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            DW'($urandom),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
